// File: rtl/fnd_scan_if.sv
// Control and scan-output bundle between an FND scan controller and its host.
interface fnd_scan_if;
  logic       i_en;
  logic [7:0] i_mask;
  logic [2:0] i_last_digit;
  logic [2:0] o_sel;
  logic [7:0] o_digit_n;
  logic       o_scan_tick;
  logic       o_frame_done;

  modport master (
    output i_en, i_mask, i_last_digit,
    input  o_sel, o_digit_n, o_scan_tick, o_frame_done
  );

  modport slave (
    input  i_en, i_mask, i_last_digit,
    output o_sel, o_digit_n, o_scan_tick, o_frame_done
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 8-digit FND scan sequencer with anti-ghosting blank gap,
// per-digit masking and a programmable last digit.
//
//  state    | meaning
//  ST_OFF   | display off, all anodes high, o_sel held at 0
//  ST_BLANK | all anodes high while the digit mux settles on the new o_sel
//  ST_DRIVE | anode o_sel driven low (unless masked) for DIGIT_CYCLES clocks
module fnd_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic     i_clk,
  input  logic     i_reset,
  fnd_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int DIGIT_LAST = DIGIT_CYCLES - 1;

  // With no blank gap the sequencer never visits ST_BLANK.
  localparam state_e ST_AFTER_ADV = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         digit_n_q, digit_n_d;
  logic               tick_q, tick_d;
  logic               frame_q, frame_d;
  logic               advance;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      sel_q     <= 3'd0;
      digit_n_q <= 8'hFF;
      tick_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      digit_n_q <= digit_n_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    advance = 1'b0;
    if (!bus.i_en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_AFTER_ADV;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_LAST)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(DIGIT_LAST)) begin
            advance = 1'b1;
            state_d = ST_AFTER_ADV;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    sel_d     = sel_q;
    tick_d    = 1'b0;
    frame_d   = 1'b0;
    digit_n_d = 8'hFF;
    if (state_d == ST_OFF) begin
      sel_d = 3'd0;
    end else if (advance) begin
      sel_d   = (sel_q >= bus.i_last_digit) ? 3'd0 : sel_q + 3'd1;
      tick_d  = 1'b1;
      frame_d = (sel_d == 3'd0);
    end
    if (state_d == ST_DRIVE) begin
      digit_n_d = ~(8'(bus.i_mask[sel_d]) << sel_d);
    end
  end

  assign bus.o_sel        = sel_q;
  assign bus.o_digit_n    = digit_n_q;
  assign bus.o_scan_tick  = tick_q;
  assign bus.o_frame_done = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: an arithmetic scan model fills
// per-DUT expectation queues that are popped and checked on each falling edge.
module tb_fnd_scan_controller;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [12:0] q_a[$];
  logic [12:0] q_b[$];

  fnd_scan_if bus_a ();
  fnd_scan_if bus_b ();

  fnd_scan_controller #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(17)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a)
  );

  fnd_scan_controller #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(17)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {digit_n, sel, tick, frame} after the e-th edge since enable.
  function automatic logic [12:0] model(input int e, input logic [7:0] mask,
                                        input int last, input int b, input int d);
    int         p;
    int         j;
    logic [2:0] s;
    logic [7:0] dn;
    logic       tk;
    logic       fr;
    p  = (e - 1) % (b + d);
    j  = (e - 1) / (b + d);
    s  = 3'(j % (last + 1));
    dn = 8'hFF;
    if (p >= b && mask[s]) dn[s] = 1'b0;
    tk = (p == 0) && (j >= 1);
    fr = tk && (s == 3'd0);
    return {dn, s, tk, fr};
  endfunction

  task automatic push_a(input int e0, input int e1, input logic [7:0] mask, input int last);
    for (int e = e0; e <= e1; e++) q_a.push_back(model(e, mask, last, 2, 4));
  endtask

  task automatic push_b(input int e0, input int e1, input logic [7:0] mask, input int last);
    for (int e = e0; e <= e1; e++) q_b.push_back(model(e, mask, last, 0, 4));
  endtask

  task automatic report(input string tag, input logic [12:0] got, input logic [12:0] exp_v);
    $error("FAIL %s: got dn=%h sel=%0d tick=%b frame=%b, expected dn=%h sel=%0d tick=%b frame=%b",
           tag, got[12:5], got[4:2], got[1], got[0], exp_v[12:5], exp_v[4:2], exp_v[1], exp_v[0]);
  endtask

  task automatic check_a(input string tag);
    logic [12:0] exp_v;
    logic [12:0] got;
    @(negedge clk);
    exp_v = q_a.pop_front();
    got   = {bus_a.o_digit_n, bus_a.o_sel, bus_a.o_scan_tick, bus_a.o_frame_done};
    vectors++;
    assert (got === exp_v) else begin
      miscompares++;
      report(tag, got, exp_v);
    end
  endtask

  task automatic check_b(input string tag);
    logic [12:0] exp_v;
    logic [12:0] got;
    @(negedge clk);
    exp_v = q_b.pop_front();
    got   = {bus_b.o_digit_n, bus_b.o_sel, bus_b.o_scan_tick, bus_b.o_frame_done};
    vectors++;
    assert (got === exp_v) else begin
      miscompares++;
      report(tag, got, exp_v);
    end
  endtask

  task automatic run_a(input int n, input string tag);
    for (int i = 0; i < n; i++) check_a(tag);
  endtask

  // Turn A off for one clock, then re-enable with new settings.
  task automatic restart_a(input logic [7:0] mask, input logic [2:0] last);
    bus_a.i_en = 1'b0;
    q_a.push_back({8'hFF, 3'd0, 1'b0, 1'b0});
    check_a("off_before_restart");
    bus_a.i_en         = 1'b1;
    bus_a.i_mask       = mask;
    bus_a.i_last_digit = last;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      assert ($countones(~bus_a.o_digit_n) <= 1) else begin
        miscompares++;
        $error("FAIL onehot_a: got dn=%h, expected at most one bit low", bus_a.o_digit_n);
      end
      assert ($countones(~bus_b.o_digit_n) <= 1) else begin
        miscompares++;
        $error("FAIL onehot_b: got dn=%h, expected at most one bit low", bus_b.o_digit_n);
      end
    end
  end

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b0;
    bus_a.i_en         = 1'b0;
    bus_a.i_mask       = 8'hFF;
    bus_a.i_last_digit = 3'd7;
    bus_b.i_en         = 1'b0;
    bus_b.i_mask       = 8'hFF;
    bus_b.i_last_digit = 3'd7;
    #1 rst = 1'b1;

    q_a.push_back({8'hFF, 3'd0, 1'b0, 1'b0});
    check_a("reset_state");

    // 1: full 8-digit scan after reset release
    rst        = 1'b0;
    bus_a.i_en = 1'b1;
    push_a(1, 49, 8'hFF, 7);
    run_a(49, "full_scan");

    // 2: alternating digit mask
    restart_a(8'b1010_1010, 3'd7);
    push_a(1, 49, 8'b1010_1010, 7);
    run_a(49, "masked_scan");

    // 3a: three-digit display
    restart_a(8'hFF, 3'd2);
    push_a(1, 37, 8'hFF, 2);
    run_a(37, "last_digit_2");

    // 3b: lower last digit while digit 5 is driven
    restart_a(8'hFF, 3'd7);
    push_a(1, 34, 8'hFF, 7);
    run_a(34, "pre_lower");
    bus_a.i_last_digit = 3'd2;
    q_a.push_back({8'hDF, 3'd5, 1'b0, 1'b0});
    q_a.push_back({8'hDF, 3'd5, 1'b0, 1'b0});
    run_a(2, "lowered_hold");
    push_a(37, 55, 8'hFF, 2);
    run_a(19, "lowered_wrap");

    // 4: drop enable on the clock that would advance from digit 3
    restart_a(8'hFF, 3'd7);
    push_a(1, 24, 8'hFF, 7);
    run_a(24, "pre_disable");
    bus_a.i_en = 1'b0;
    q_a.push_back({8'hFF, 3'd0, 1'b0, 1'b0});
    check_a("disable_on_advance");
    bus_a.i_en = 1'b1;
    push_a(1, 10, 8'hFF, 7);
    run_a(10, "reenable");

    // 5: asynchronous reset between edges while driving digit 1
    #2 rst = 1'b1;
    #1;
    vectors++;
    assert (bus_a.o_digit_n === 8'hFF && bus_a.o_sel === 3'd0) else begin
      miscompares++;
      $error("FAIL async_reset: got dn=%h sel=%0d, expected dn=ff sel=0",
             bus_a.o_digit_n, bus_a.o_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    push_a(1, 8, 8'hFF, 7);
    run_a(8, "after_reset");

    // 6: no-blank build scans digits back to back
    bus_a.i_en = 1'b0;
    bus_b.i_en = 1'b1;
    push_b(1, 33, 8'hFF, 7);
    for (int i = 0; i < 33; i++) check_b("no_blank");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
